// File: rtl/udp_payload_unpack.sv
// Reassembles a fixed-length, MSB-first UDP payload from the 32-bit receive word stream.
// Results appear one cycle after rec_pkt_done; packets of the wrong length are dropped and counted.
module udp_payload_unpack #(
  parameter int PAYLOAD_BYTES = 11,
  parameter int PAYLOAD_BITS  = 88,
  parameter int WORDS         = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rec_en,
  input  logic [31:0]             rec_data,
  input  logic                    rec_pkt_done,
  input  logic [15:0]             rec_byte_num,
  output logic [PAYLOAD_BITS-1:0] o_payload,
  output logic                    payload_valid,
  output logic                    len_err,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int BW  = WORDS * 32;
  localparam int CW  = $clog2(WORDS + 2);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t        state;
  logic [CW-1:0] word_cnt;
  logic [BW-1:0] buffer;

  logic          store;
  logic [BW-1:0] buf_next;
  logic [CW1-1:0] eff_cnt;
  logic          accept;

  // A word arriving together with rec_pkt_done is part of the packet being judged,
  // so evaluation looks at the buffer and count as they will be after this cycle.
  always_comb begin
    store    = rec_en && (word_cnt < CW'(WORDS)) && (state != DISCARD);
    buf_next = store ? BW'({buffer, rec_data}) : buffer;
    eff_cnt  = {1'b0, word_cnt} + CW1'(rec_en);
    accept   = (rec_byte_num == 16'(PAYLOAD_BYTES)) && (eff_cnt == CW1'(WORDS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      word_cnt      <= '0;
      buffer        <= '0;
      o_payload     <= '0;
      payload_valid <= 1'b0;
      len_err       <= 1'b0;
      pkt_cnt       <= '0;
      drop_cnt      <= '0;
    end else begin
      payload_valid <= 1'b0;
      len_err       <= 1'b0;
      buffer        <= buf_next;

      if (rec_en && (word_cnt != CW'(WORDS + 1)))
        word_cnt <= word_cnt + CW'(1);

      case (state)
        IDLE:    if (rec_en) state <= COLLECT;
        COLLECT: if (rec_en && (word_cnt == CW'(WORDS))) state <= DISCARD;
        default: ;
      endcase

      if (rec_pkt_done) begin
        state    <= IDLE;
        word_cnt <= '0;
        if (accept) begin
          // Pad bytes in the low end of the last word fall off the bottom here.
          o_payload     <= buf_next[BW-1 -: PAYLOAD_BITS];
          payload_valid <= 1'b1;
          pkt_cnt       <= pkt_cnt + 16'd1;
        end else begin
          len_err  <= 1'b1;
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_unpack.sv
// Bench for udp_payload_unpack: table of packets against a scoreboard, plus reset and counter-wrap sequences.
module tb_udp_payload_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic [87:0] o_payload;
  logic        payload_valid;
  logic        len_err;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  // Single-word instance used only for the long counter-wrap run.
  logic        s_en;
  logic [31:0] s_data;
  logic        s_done;
  logic [15:0] s_bn;
  logic [31:0] s_payload;
  logic        s_valid;
  logic        s_err;
  logic [15:0] s_pkt;
  logic [15:0] s_drop;

  always #5 clk = ~clk;

  udp_payload_unpack #(.PAYLOAD_BYTES(11), .PAYLOAD_BITS(88), .WORDS(3)) dut (
    .clk(clk), .rst(rst), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
    .o_payload(o_payload), .payload_valid(payload_valid), .len_err(len_err),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  udp_payload_unpack #(.PAYLOAD_BYTES(4), .PAYLOAD_BITS(32), .WORDS(1)) dut_w (
    .clk(clk), .rst(rst), .rec_en(s_en), .rec_data(s_data),
    .rec_pkt_done(s_done), .rec_byte_num(s_bn),
    .o_payload(s_payload), .payload_valid(s_valid), .len_err(s_err),
    .pkt_cnt(s_pkt), .drop_cnt(s_drop)
  );

  typedef struct {
    int              n;
    logic [15:0]     bn;
    bit              sep;
    logic [4:0][31:0] w;
    bit              ok;
    logic [87:0]     pl;
  } vec_t;

  typedef struct {
    bit          v;
    logic [87:0] pl;
    logic [15:0] pc;
    logic [15:0] dc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [87:0] m_last = '0;
  logic [15:0] m_pkt  = '0;
  logic [15:0] m_drop = '0;
  logic        rst_seen = 1'b0;
  int          s_vcnt = 0;
  int          s_ecnt = 0;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (s_valid) s_vcnt++;
    if (s_err)   s_ecnt++;
  end

  // Scoreboard: an expected result is pushed right after the done edge, so it must
  // show up at the very next negedge; any pulse without a pending entry is spurious.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (rst_seen) begin
      if (o_payload !== '0 || payload_valid !== 1'b0 || len_err !== 1'b0 ||
          pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
        errors++;
        $display("FAIL reset_state: payload=%h vld=%b err=%b pkt=%0d drop=%0d, want all zero",
                 o_payload, payload_valid, len_err, pkt_cnt, drop_cnt);
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (payload_valid !== e.v || len_err !== !e.v || o_payload !== e.pl ||
          pkt_cnt !== e.pc || drop_cnt !== e.dc) begin
        errors++;
        $display("FAIL pkt_result: vld=%b err=%b payload=%h pkt=%0d drop=%0d, want vld=%b err=%b payload=%h pkt=%0d drop=%0d",
                 payload_valid, len_err, o_payload, pkt_cnt, drop_cnt,
                 e.v, !e.v, e.pl, e.pc, e.dc);
      end
    end else if (payload_valid !== 1'b0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_pulse: vld=%b err=%b, want 0 0", payload_valid, len_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int n, logic [15:0] bn, bit sep,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                              logic [31:0] w3, logic [31:0] w4, bit ok, logic [87:0] pl);
    vec_t v;
    v.n = n; v.bn = bn; v.sep = sep; v.ok = ok; v.pl = pl;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    return v;
  endfunction

  task automatic push_exp(bit ok, logic [87:0] pl);
    exp_t e;
    if (ok) begin
      m_pkt++;
      m_last = pl;
    end else begin
      m_drop++;
    end
    e.v = ok; e.pl = m_last; e.pc = m_pkt; e.dc = m_drop;
    q.push_back(e);
  endtask

  task automatic send_pkt(vec_t v);
    for (int i = 0; i < v.n; i++) begin
      rec_en       = 1'b1;
      rec_data     = v.w[i];
      rec_pkt_done = (!v.sep && i == v.n - 1);
      rec_byte_num = v.bn;
      tick();
    end
    if (v.sep || v.n == 0) begin
      rec_en       = 1'b0;
      rec_data     = 32'h0;
      rec_pkt_done = 1'b1;
      rec_byte_num = v.bn;
      tick();
    end
    push_exp(v.ok, v.pl);
    rec_en       = 1'b0;
    rec_pkt_done = 1'b0;
    rec_byte_num = 16'($urandom);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(3, 16'd11, 1'b0, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA00, 32'h0, 32'h0,
                 1'b1, 88'h0123456789ABCDEFFEDCBA);
    vecs[1] = mk(3, 16'd11, 1'b1, 32'h11223344, 32'h55667788, 32'h99AABB55, 32'h0, 32'h0,
                 1'b1, 88'h112233445566778899AABB);
    vecs[2] = mk(3, 16'd12, 1'b0, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'h0, 32'h0,
                 1'b0, '0);
    vecs[3] = mk(2, 16'd11, 1'b0, 32'hD0D1D2D3, 32'hE0E1E2E3, 32'h0, 32'h0, 32'h0,
                 1'b0, '0);
    vecs[4] = mk(5, 16'd11, 1'b0, 32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004,
                 32'h50000005, 1'b0, '0);
    vecs[5] = mk(3, 16'd11, 1'b0, 32'hCAFEBABE, 32'hDEADBEEF, 32'h0BADF00D, 32'h0, 32'h0,
                 1'b1, 88'hCAFEBABEDEADBEEF0BADF0);
    vecs[6] = mk(0, 16'd11, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, '0);
    vecs[7] = mk(4, 16'd11, 1'b1, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
                 32'h0, 1'b0, '0);
    vecs[8] = mk(3, 16'd11, 1'b1, 32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h0, 32'h0,
                 1'b1, 88'h76543210FEDCBA9813579B);

    rst = 1'b1;
    rec_en = 1'b0; rec_data = '0; rec_pkt_done = 1'b0; rec_byte_num = '0;
    s_en = 1'b0; s_data = '0; s_done = 1'b0; s_bn = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) send_pkt(vecs[i]);
    tick(); tick();

    // Reset after the first word: the two trailing words form a short packet.
    rec_en = 1'b1; rec_data = 32'h01234567; rec_pkt_done = 1'b0;
    tick();
    rec_en = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_last = '0; m_pkt = '0; m_drop = '0;
    send_pkt(mk(2, 16'd11, 1'b0, 32'h89ABCDEF, 32'hFEDCBA00, 32'h0, 32'h0, 32'h0, 1'b0, '0));
    tick(); tick();

    // Counter wrap on the single-word instance: one packet per cycle.
    s_vcnt = 0; s_ecnt = 0;
    for (int i = 0; i < 70000; i++) begin
      s_en = 1'b1; s_done = 1'b1; s_bn = 16'd4; s_data = $urandom;
      tick();
    end
    s_en = 1'b0; s_done = 1'b0;
    tick(); tick();

    checks++;
    if (s_pkt !== 16'd4464) begin
      errors++; $display("FAIL wrap_pkt_cnt: got %0d want 4464", s_pkt);
    end
    checks++;
    if (s_drop !== 16'd0 || s_ecnt != 0) begin
      errors++; $display("FAIL wrap_drop: drop_cnt %0d err pulses %0d, want 0 0", s_drop, s_ecnt);
    end
    checks++;
    if (s_vcnt != 70000) begin
      errors++; $display("FAIL wrap_pulses: got %0d want 70000", s_vcnt);
    end
    checks++;
    if (s_payload !== s_data) begin
      errors++; $display("FAIL wrap_payload: got %h want %h", s_payload, s_data);
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d results never seen, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_payload_unpack.md
Name: udp_payload_unpack

Overview:
- Receive-side counterpart of the fixed-length UDP payload packer used on transmit.
- Consumes the 32-bit word stream from the UDP receive path (rec_en / rec_data / rec_pkt_done / rec_byte_num), in the gmii_rx_clk domain.
- Reassembles a PAYLOAD_BYTES-byte MSB-first payload into one parallel word and flags it valid only when the packet length exactly matches.
- Counts good and dropped packets for debug/ILA.

Parameters:
- PAYLOAD_BYTES, 11: expected UDP payload length in bytes (1..64).
- PAYLOAD_BITS, 88: width of o_payload; must equal 8*PAYLOAD_BYTES.
- WORDS, 3: 32-bit words per packet; must equal ceil(PAYLOAD_BYTES/4).

Ports:
- clk  in  1  receive clock (gmii_rx_clk domain).
- rst  in  1  synchronous reset, active-high.
- rec_en  in  1  rec_data holds a valid 32-bit word this cycle.
- rec_data  in  32  payload word, first byte in [31:24].
- rec_pkt_done  in  1  one-cycle end-of-packet strobe.
- rec_byte_num  in  16  UDP payload byte count; valid when rec_pkt_done=1.
- o_payload  out  PAYLOAD_BITS  last accepted payload, first byte in MSBs.
- payload_valid  out  1  one-cycle pulse when o_payload is updated.
- len_err  out  1  one-cycle pulse when a packet is dropped.
- pkt_cnt  out  16  accepted-packet counter.
- drop_cnt  out  16  dropped-packet counter.

Behaviour:
- Reset: state=IDLE, word_cnt=0, buffer=0, o_payload=0, payload_valid=0, len_err=0, pkt_cnt=0, drop_cnt=0. Reset has priority over all inputs in the same cycle.
- Buffer: WORDS*32 bits. On each rec_en while word_cnt<WORDS, the buffer shifts left 32 and loads rec_data into the low word.
- Packing rule (inverse of transmit): word k maps to buffer bits [WORDS*32-1-32k -: 32]. o_payload = buffer[WORDS*32-1 -: PAYLOAD_BITS]. Pad bytes in the last word's low bits are discarded. For 11 bytes: w0 to [87:56], w1 to [55:24], w2[31:8] to [23:0].
- word_cnt: increments on rec_en and saturates at WORDS+1.
- FSM states:
  - IDLE: rec_en goes to COLLECT (word stored).
  - COLLECT: rec_en with word_cnt==WORDS goes to DISCARD (word not stored; buffer frozen).
  - DISCARD: further words are ignored.
  - Any state: rec_pkt_done evaluates the packet, then returns to IDLE with word_cnt=0 on the next cycle.
- rec_en and rec_pkt_done in the same cycle: the word counts toward the current packet and is stored before evaluation, i.e. effective count = word_cnt + rec_en.
- Accept condition: rec_byte_num==PAYLOAD_BYTES and effective count==WORDS.
  - On the cycle after rec_pkt_done: o_payload <= assembled buffer, payload_valid=1 for one cycle, pkt_cnt+1.
- Reject (any other case, including rec_pkt_done with zero words):
  - o_payload holds its previous value, len_err=1 for one cycle, drop_cnt+1.
- Latency: rec_pkt_done at cycle N gives payload_valid/len_err at cycle N+1. A new packet's rec_en at N+1 is accepted (IDLE entered with word_cnt=0 at N+1).
- Counters wrap from 0xFFFF to 0x0000 without any flag.
- Reset mid-packet discards the partial data. Words arriving after reset release start a new packet; a truncated tail therefore fails the length check and is dropped.
- rec_byte_num is ignored except when rec_pkt_done=1.
- payload_valid and len_err are never high in the same cycle.

Test Plan:
- Good packet: 3 words 0x01234567, 0x89ABCDEF, 0xFEDCBA00 with rec_byte_num=11, done on the last word's cycle -> o_payload=0x0123456789ABCDEFFEDCBA, payload_valid pulses 1 cycle at N+1, pkt_cnt=1.
- Done one cycle after the last word (separate strobe) -> same payload, same single pulse; the pad byte value (e.g. 0x55) does not appear in o_payload.
- Length mismatch: 3 words with rec_byte_num=12; then 2 words with rec_byte_num=11 -> len_err pulses twice, drop_cnt=2, o_payload unchanged from the previous good value.
- Overlong: 5 words, rec_byte_num=11 -> len_err, drop_cnt+1. An immediately following good packet (first rec_en at N+1) is accepted correctly.
- Reset asserted after word 1 of 3; the remaining 2 words then done with rec_byte_num=11 -> all outputs 0 during reset, then len_err, drop_cnt=1, o_payload=0.
- Back-to-back: 70000 good packets -> pkt_cnt wraps to 70000-65536=4464, drop_cnt=0, each packet produces exactly one payload_valid pulse.
